// File: rtl/timer_us_sched_pkg.sv
// Shared types and constants for the interval-timer scheduler.
// Holds the FSM state encoding, the timer register map and the period clamp.
package timer_us_sched_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD_L = 4'd1,
    LOAD_H = 4'd2,
    CLR    = 4'd3,
    ARM    = 4'd4,
    WAIT   = 4'd5,
    ACK    = 4'd6,
    CANCEL = 4'd7,
    DISARM = 4'd8
  } state_t;

  localparam logic [2:0] STATUS  = 3'd0;
  localparam logic [2:0] CONTROL = 3'd1;
  localparam logic [2:0] PERIODL = 3'd2;
  localparam logic [2:0] PERIODH = 3'd3;

  localparam int unsigned MIN_PERIOD = 2;

  // The timer counts value..0 inclusive, so an interval of p cycles needs p-1.
  function automatic logic [31:0] prog_value(input logic [31:0] p);
    if (p < 32'(MIN_PERIOD)) begin
      return 32'(MIN_PERIOD - 1);
    end
    return p - 32'd1;
  endfunction

endpackage

// File: rtl/timer_us_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches req starting at i_ptr and wrapping modulo N.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_en,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  int w_k;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = 0;
    for (int j = 0; j < N; j++) begin
      w_k = int'(i_ptr) + j;
      if (w_k >= N) begin
        w_k = w_k - N;
      end
      if (i_en && !o_valid && i_req[w_k[IW-1:0]]) begin
        o_valid              = 1'b1;
        o_idx                = w_k[IW-1:0];
        o_grant[w_k[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_us_scheduler.sv
// Time-shares one 32-bit Avalon-MM interval timer among N_REQ requesters.
// Outputs are registered from the next state so each state's bus cycle lines up with it.
module timer_us_scheduler
  import timer_us_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [32*N_REQ-1:0]  req_period,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic [2:0]           tmr_address,
  output logic                 tmr_chipselect,
  output logic                 tmr_write_n,
  output logic [15:0]          tmr_writedata,
  input  logic                 tmr_irq
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_g;
  logic [IW-1:0]     r_ptr;
  logic [31:0]       r_value;
  logic              r_armed;

  logic [N_REQ-1:0]  w_arb_grant;
  logic [IW-1:0]     w_arb_idx;
  logic              w_arb_valid;
  logic              w_start;
  logic [31:0]       w_sel_period;
  logic [31:0]       w_value_nxt;
  logic [N_REQ-1:0]  w_onehot;

  logic              w_cs;
  logic              w_wn;
  logic [2:0]        w_addr;
  logic [15:0]       w_wdata;
  logic [N_REQ-1:0]  w_grant_nxt;
  logic [N_REQ-1:0]  w_done_nxt;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_en    (r_state == IDLE),
    .o_grant (w_arb_grant),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_start = w_arb_valid;

  always_comb begin
    w_sel_period = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_arb_idx == IW'(i)) begin
        w_sel_period = req_period[32*i +: 32];
      end
    end
  end

  // Values seen by the next state: freshly arbitrated in IDLE, latched otherwise.
  assign w_value_nxt = w_start ? prog_value(w_sel_period) : r_value;
  assign w_onehot    = w_start ? w_arb_grant : (N_REQ'(1) << r_g);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = LOAD_L;
        end else if (r_armed) begin
          w_state_nxt = DISARM;
        end
      end
      LOAD_L: w_state_nxt = LOAD_H;
      LOAD_H: w_state_nxt = CLR;
      CLR:    w_state_nxt = ARM;
      ARM:    w_state_nxt = WAIT;
      WAIT: begin
        if (tmr_irq) begin
          w_state_nxt = ACK;
        end else if (!req[r_g]) begin
          w_state_nxt = CANCEL;
        end
      end
      ACK:    w_state_nxt = IDLE;
      CANCEL: w_state_nxt = IDLE;
      DISARM: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cs        = 1'b0;
    w_wn        = 1'b1;
    w_addr      = STATUS;
    w_wdata     = '0;
    w_grant_nxt = '0;
    w_done_nxt  = '0;
    unique case (w_state_nxt)
      LOAD_L: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = PERIODL;
        w_wdata = w_value_nxt[15:0];
      end
      LOAD_H: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = PERIODH;
        w_wdata = w_value_nxt[31:16];
      end
      CLR, CANCEL: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = STATUS;
      end
      ARM: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = CONTROL;
        w_wdata = 16'd1;
      end
      ACK: begin
        w_cs       = 1'b1;
        w_wn       = 1'b0;
        w_addr     = STATUS;
        w_done_nxt = w_onehot;
      end
      DISARM: begin
        w_cs    = 1'b1;
        w_wn    = 1'b0;
        w_addr  = CONTROL;
      end
      default: begin
      end
    endcase
    if (w_state_nxt != IDLE && w_state_nxt != DISARM) begin
      w_grant_nxt = w_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_g     <= '0;
      r_ptr   <= '0;
      r_value <= '0;
      r_armed <= 1'b0;
    end else begin
      if (w_start) begin
        r_g     <= w_arb_idx;
        r_value <= w_value_nxt;
        r_ptr   <= (w_arb_idx == IW'(N_REQ - 1)) ? '0 : w_arb_idx + IW'(1);
      end
      if (r_state == ARM) begin
        r_armed <= 1'b1;
      end else if (r_state == DISARM) begin
        r_armed <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant          <= '0;
      done           <= '0;
      busy           <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      grant          <= w_grant_nxt;
      done           <= w_done_nxt;
      busy           <= (w_state_nxt != IDLE);
      tmr_chipselect <= w_cs;
      tmr_write_n    <= w_wn;
      tmr_address    <= w_addr;
      tmr_writedata  <= w_wdata;
    end
  end

endmodule

// File: tb/tb_timer_us_scheduler.sv
// Bench for timer_us_scheduler with a behavioural interval timer as the slave.
// Expected bus writes, grant order and done timing come from a transaction-level model.
module tb_timer_us_scheduler;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_period;
  logic [N-1:0]    grant;
  logic [N-1:0]    done;
  logic            busy;
  logic [2:0]      tmr_address;
  logic            tmr_chipselect;
  logic            tmr_write_n;
  logic [15:0]     tmr_writedata;
  logic            tmr_irq;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_g = N - 1;

  typedef struct {
    int         cyc;
    logic [2:0] a;
    logic [15:0] d;
    logic [3:0] g;
  } wr_t;
  wr_t wq[$];

  timer_us_scheduler #(.N_REQ(N)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .req_period     (req_period),
    .grant          (grant),
    .done           (done),
    .busy           (busy),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_irq        (tmr_irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Interval timer: writing period_h reloads and starts; wraps every period+1 cycles.
  logic [15:0] t_perl, t_perh;
  logic [31:0] t_cnt;
  logic        t_run, t_to, t_ito;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_perl <= '0; t_perh <= '0; t_cnt <= '0;
      t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0;
    end else begin
      if (t_run) begin
        if (t_cnt == 0) begin
          t_to  <= 1'b1;
          t_cnt <= {t_perh, t_perl};
        end else begin
          t_cnt <= t_cnt - 1;
        end
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd0: t_to  <= 1'b0;
          3'd1: t_ito <= tmr_writedata[0];
          3'd2: t_perl <= tmr_writedata;
          3'd3: begin
            t_perh <= tmr_writedata;
            t_cnt  <= {tmr_writedata, t_perl};
            t_run  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
  assign tmr_irq = t_to & t_ito;

  always @(negedge clk) begin
    wr_t w;
    if (reset_n) begin
      if (tmr_chipselect && !tmr_write_n) begin
        w.cyc = cyc; w.a = tmr_address; w.d = tmr_writedata; w.g = grant;
        wq.push_back(w);
      end
      if (done != 0) done_cnt++;
      checks++;
      assert ($onehot0(grant) && ((done & ~grant) === 4'b0)) else begin
        errors++;
        $error("FAIL grant_onehot: grant=%b done=%b, required one-hot-or-zero grant covering done", grant, done);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input logic [3:0] pend, input int last);
    for (int j = 1; j <= N; j++) begin
      if (pend[(last + j) % N]) return (last + j) % N;
    end
    return -1;
  endfunction

  task automatic check_reset(input string tag);
    checks++;
    assert (grant === 4'b0 && done === 4'b0 && busy === 1'b0) else begin
      errors++;
      $error("FAIL %s_ctl: grant=%b done=%b busy=%b, required 0000/0000/0", tag, grant, done, busy);
    end
    checks++;
    assert (tmr_chipselect === 1'b0 && tmr_write_n === 1'b1 && tmr_address === 3'd0 && tmr_writedata === 16'd0) else begin
      errors++;
      $error("FAIL %s_bus: cs=%b wn=%b a=%0d d=%h, required 0/1/0/0000", tag, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata);
    end
  endtask

  task automatic expect_write(input logic [2:0] ea, input logic [15:0] ed, input logic [3:0] eg,
                              input string tag, output int wcyc);
    int n = 0;
    wr_t w;
    wcyc = -1;
    while (wq.size() == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (wq.size() != 0) else begin
      errors++;
      $error("FAIL %s: no write within 20 cycles, required a=%0d d=%h", tag, ea, ed);
    end
    if (wq.size() != 0) begin
      w = wq.pop_front();
      wcyc = w.cyc;
      checks++;
      assert (w.a === ea && w.d === ed && w.g === eg) else begin
        errors++;
        $error("FAIL %s: got a=%0d d=%h grant=%b, required a=%0d d=%h grant=%b", tag, w.a, w.d, w.g, ea, ed, eg);
      end
    end
  endtask

  task automatic wait_done(input int limit, input string tag, output logic [3:0] dv, output int dc);
    int n = 0;
    dv = '0;
    dc = -1;
    while (n < limit && dv == 0) begin
      @(negedge clk);
      n++;
      if (done != 0) begin
        dv = done;
        dc = cyc;
      end
    end
    checks++;
    assert (dv != 0) else begin
      errors++;
      $error("FAIL %s: done=%b after %0d cycles, required a done pulse", tag, dv, limit);
    end
  endtask

  task automatic program_seq(input int e, input logic [31:0] p, input string tag, output int arm_c);
    logic [31:0] v;
    int wc;
    v = (p < 2) ? 32'd1 : p - 1;
    expect_write(3'd2, v[15:0],  4'(1 << e), {tag, "_pl"}, wc);
    expect_write(3'd3, v[31:16], 4'(1 << e), {tag, "_ph"}, wc);
    expect_write(3'd0, 16'd0,    4'(1 << e), {tag, "_clr"}, wc);
    expect_write(3'd1, 16'd1,    4'(1 << e), {tag, "_arm"}, arm_c);
  endtask

  // Each requester in mask is served once, dropping req on its done cycle.
  task automatic run_batch(input logic [3:0] mask, input logic [127:0] pv, input string tag);
    logic [3:0] pend, dv;
    logic [31:0] p, pp;
    int e, arm_c, dc, wc;
    req_period = pv;
    @(negedge clk);
    req = mask;
    pend = mask;
    while (pend != 0) begin
      e  = rr_pick(pend, last_g);
      p  = pv[32*e +: 32];
      pp = (p < 2) ? 32'd2 : p;
      program_seq(e, p, tag, arm_c);
      wait_done(int'(pp) + 50, {tag, "_done"}, dv, dc);
      req[e] = 1'b0;
      pend[e] = 1'b0;
      last_g = e;
      checks++;
      assert (dv === 4'(1 << e)) else begin
        errors++;
        $error("FAIL %s_who: done=%b, required %b", tag, dv, 4'(1 << e));
      end
      checks++;
      assert (dc - arm_c >= int'(pp) - 2 && dc - arm_c <= int'(pp) + 2) else begin
        errors++;
        $error("FAIL %s_lat: arm-to-done=%0d, required %0d+-2", tag, dc - arm_c, pp);
      end
      expect_write(3'd0, 16'd0, 4'(1 << e), {tag, "_ack"}, wc);
      checks++;
      assert (wc === dc) else begin
        errors++;
        $error("FAIL %s_ackcyc: ack write cycle=%0d, required %0d", tag, wc, dc);
      end
    end
    expect_write(3'd1, 16'd0, 4'b0000, {tag, "_disarm"}, wc);
    @(negedge clk);
    checks++;
    assert (busy === 1'b0) else begin
      errors++;
      $error("FAIL %s_idle: busy=%b, required 0", tag, busy);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clk);
    check_reset("rst");
    wq.delete();
    reset_n = 1'b1;
    last_g = N - 1;
  endtask

  initial begin
    logic [127:0] pv;
    logic [3:0]   m, dv;
    int           arm_c, dc, prev_d, prev_sp, sp, wc, dc0;

    reset_n = 1'b0;
    req = '0;
    req_period = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;

    // single request, period 100
    pv = '0; pv[31:0] = 32'd100;
    run_batch(4'b0001, pv, "single");

    // contention from reset: order 0,1,2,3
    do_reset();
    pv = '0;
    for (int k = 0; k < N; k++) pv[32*k +: 32] = 32'($urandom_range(20, 60));
    run_batch(4'b1111, pv, "cont");

    // periodic service of requester 2
    req_period = '0;
    req_period[95:64] = 32'd50;
    @(negedge clk);
    req = 4'b0100;
    prev_d = 0; prev_sp = 0;
    for (int k = 0; k < 4; k++) begin
      program_seq(2, 32'd50, "per", arm_c);
      wait_done(100, "per_done", dv, dc);
      if (k == 3) req[2] = 1'b0;
      checks++;
      assert (dv === 4'b0100) else begin
        errors++;
        $error("FAIL per_who: done=%b, required 0100", dv);
      end
      if (k > 0) begin
        sp = dc - prev_d;
        checks++;
        assert (sp >= 53 && sp <= 57 && (k == 1 || sp == prev_sp)) else begin
          errors++;
          $error("FAIL per_spacing: spacing=%0d prev=%0d, required constant 55+-2", sp, prev_sp);
        end
        prev_sp = sp;
      end
      prev_d = dc;
      expect_write(3'd0, 16'd0, 4'b0100, "per_ack", wc);
    end
    last_g = 2;
    expect_write(3'd1, 16'd0, 4'b0000, "per_disarm", wc);

    // cancel requester 1 ten cycles into WAIT
    req_period = '0;
    req_period[63:32] = 32'd1000;
    @(negedge clk);
    req = 4'b0010;
    program_seq(1, 32'd1000, "can", arm_c);
    repeat (10) @(negedge clk);
    dc0 = done_cnt;
    req[1] = 1'b0;
    expect_write(3'd0, 16'd0, 4'b0010, "can_clr", wc);
    expect_write(3'd1, 16'd0, 4'b0000, "can_disarm", wc);
    last_g = 1;
    checks++;
    assert (done_cnt === dc0) else begin
      errors++;
      $error("FAIL can_nodone: done pulses=%0d, required %0d", done_cnt, dc0);
    end

    // boundaries
    pv = '0;
    run_batch(4'b0001, pv, "bnd0");
    pv[31:0] = 32'h0001_0000;
    run_batch(4'b0001, pv, "bnd64k");

    // randomized batches
    for (int r = 0; r < 3; r++) begin
      m = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) pv[32*k +: 32] = 32'($urandom_range(0, 40));
      run_batch(m, pv, "rnd");
    end

    // reset during WAIT of requester 1, then restart from pointer 0
    req_period = '0;
    req_period[63:32] = 32'd500;
    @(negedge clk);
    req = 4'b0010;
    program_seq(1, 32'd500, "prerst", arm_c);
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset("midrst");
    pv = '0;
    pv[63:32]  = 32'($urandom_range(2, 30));
    pv[127:96] = 32'($urandom_range(2, 30));
    req_period = pv;
    req = 4'b1010;
    wq.delete();
    last_g = N - 1;
    @(negedge clk);
    reset_n = 1'b1;
    run_batch(4'b1010, pv, "postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
